// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the ALU arbiter: FSM state encoding, default hold limit
// and the sr_cpu ALU opcodes.
package alu_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  localparam int ARB_MAX_HOLD_DEF = 64;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SRL  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b100;

  // Width of an index into n requesters, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: searches req_i starting just after last_i and returns
// the first hit as one-hot gnt_o plus its index.
module alu_arbiter_rr_pick
  import alu_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int LW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [LW-1:0]   last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [LW-1:0]   idx_o,
  output logic            vld_o
);

  logic [LW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = LW'((int'(last_i) + k) % NREQ);
      if (!vld_o && req_i[cand]) begin
        vld_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin, lock-until-release arbiter sharing one combinational ALU between NREQ units.
// Optional forced revoke after MAX_HOLD owned cycles is enabled by defining ALU_ARB_TIMEOUT_EN.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int W        = 8,
  parameter int MAX_HOLD = ARB_MAX_HOLD_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*W-1:0] a_i,
  input  logic [NREQ*W-1:0] b_i,
  input  logic [NREQ*3-1:0] op_i,
  output logic [NREQ-1:0]   grant_o,
  output logic [W-1:0]      res_o,
  output logic [W-1:0]      alu_a_o,
  output logic [W-1:0]      alu_b_o,
  output logic [2:0]        alu_op_o,
  input  logic [W-1:0]      alu_res_i,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam int LW = idx_w(NREQ);
  localparam int CW = $clog2(MAX_HOLD + 1);

  if (NREQ < 2 || NREQ > 8 || MAX_HOLD < 1) begin : g_bad_cfg
    $error("alu_arbiter: NREQ must be 2..8 and MAX_HOLD at least 1");
  end

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [LW-1:0]   last_q, last_d;
  logic [NREQ-1:0] pick_req, pick_gnt;
  logic [LW-1:0]   pick_idx;
  logic            pick_vld;
  logic            arbitrate;

  logic [W-1:0] a_arr  [NREQ];
  logic [W-1:0] b_arr  [NREQ];
  logic [2:0]   op_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g]  = a_i[g*W +: W];
    assign b_arr[g]  = b_i[g*W +: W];
    assign op_arr[g] = op_i[g*3 +: 3];
  end

`ifdef ALU_ARB_TIMEOUT_EN
  logic [CW-1:0]   hold_q, hold_d;
  logic [NREQ-1:0] mask_q, mask_d;
  logic            timeout_q, timeout_d;

  // The current owner and any unit revoked by timeout are excluded from the next pick.
  assign pick_req  = req_i & ~grant_q & ~mask_q;
  assign timeout_o = timeout_q;
`else
  assign pick_req  = req_i & ~grant_q;
  assign timeout_o = 1'b0;
`endif

  alu_arbiter_rr_pick #(
    .NREQ (NREQ),
    .LW   (LW)
  ) u_rr_pick (
    .req_i  (pick_req),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .vld_o  (pick_vld)
  );

  // While OWNED, last_q is the owner index, so it doubles as the mux select.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    arbitrate = 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
    hold_d    = hold_q;
    mask_d    = mask_q & req_i;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: arbitrate = 1'b1;
      ARB_OWNED: begin
        if (!req_i[last_q]) begin
          arbitrate = 1'b1;
        end
`ifdef ALU_ARB_TIMEOUT_EN
        else if (hold_q == CW'(MAX_HOLD - 1)) begin
          arbitrate      = 1'b1;
          timeout_d      = 1'b1;
          mask_d[last_q] = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
`endif
      end
      default: state_d = ARB_IDLE;
    endcase
    if (arbitrate) begin
      if (pick_vld) begin
        grant_d = pick_gnt;
        last_d  = pick_idx;
        state_d = ARB_OWNED;
`ifdef ALU_ARB_TIMEOUT_EN
        hold_d  = '0;
`endif
      end else begin
        grant_d = '0;
        state_d = ARB_IDLE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      last_q    <= LW'(NREQ - 1);
`ifdef ALU_ARB_TIMEOUT_EN
      hold_q    <= '0;
      mask_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
`ifdef ALU_ARB_TIMEOUT_EN
      hold_q    <= hold_d;
      mask_q    <= mask_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  always_comb begin
    alu_a_o  = '0;
    alu_b_o  = '0;
    alu_op_o = '0;
    if (state_q == ARB_OWNED) begin
      alu_a_o  = a_arr[last_q];
      alu_b_o  = b_arr[last_q];
      alu_op_o = op_arr[last_q];
    end
  end

  assign res_o   = alu_res_i;
  assign grant_o = grant_q;
  assign busy_o  = |grant_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU; define ALU_ARB_TIMEOUT_EN to also
// exercise the forced-revoke path (MAX_HOLD=4).
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int NREQ = 2;
  localparam int W    = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [1:0]      req = '0;
  logic [7:0]      a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [2:0]      op0 = '0, op1 = '0;
  logic [1:0]      grant;
  logic [7:0]      res, alu_a, alu_b, alu_res;
  logic [2:0]      alu_op;
  logic            busy, timeout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(NREQ), .W(W), .MAX_HOLD(4)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .a_i       ({a1, a0}),
    .b_i       ({b1, b0}),
    .op_i      ({op1, op0}),
    .grant_o   (grant),
    .res_o     (res),
    .alu_a_o   (alu_a),
    .alu_b_o   (alu_b),
    .alu_op_o  (alu_op),
    .alu_res_i (alu_res),
    .busy_o    (busy),
    .timeout_o (timeout)
  );

  // Behavioural stand-in for the sr_cpu ALU.
  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:  alu_res = alu_a + alu_b;
      ALU_OR:   alu_res = alu_a | alu_b;
      ALU_SRL:  alu_res = alu_a >> alu_b;
      ALU_SLTU: alu_res = {7'd0, alu_a < alu_b};
      ALU_SUB:  alu_res = alu_a - alu_b;
      default:  alu_res = '0;
    endcase
  end

  typedef struct {
    logic [1:0] req;
    logic [7:0] a0, b0;
    logic [2:0] op0;
    logic [7:0] a1, b1;
    logic [2:0] op1;
    logic [1:0] grant;
    logic [7:0] res;
    logic [7:0] alu_a;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] r, input logic [1:0] eg, input string nm);
    req = r;
    @(posedge clk);
    #1;
    chk({nm, " grant"}, 32'(grant), 32'(eg));
    chk({nm, " busy"}, 32'(busy), 32'(|eg));
  endtask

  task automatic set_ops();
    a0 = 8'd9;  b0 = 8'd3; op0 = ALU_SUB;
    a1 = 8'd20; b1 = 8'd5; op1 = ALU_ADD;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            req    a0     b0     op0      a1     b1     op1       grant  res     alu_a
    vecs[0]  = '{2'b01, 8'd9,  8'd3,  ALU_SUB, 8'd20, 8'd5, ALU_ADD,  2'b01, 8'd6,   8'd9};
    vecs[1]  = '{2'b01, 8'd9,  8'd3,  ALU_SUB, 8'd20, 8'd5, ALU_ADD,  2'b01, 8'd6,   8'd9};
    vecs[2]  = '{2'b11, 8'd9,  8'd3,  ALU_SUB, 8'd20, 8'd5, ALU_ADD,  2'b01, 8'd6,   8'd9};
    vecs[3]  = '{2'b10, 8'd9,  8'd3,  ALU_SUB, 8'd20, 8'd5, ALU_ADD,  2'b10, 8'd25,  8'd20};
    vecs[4]  = '{2'b11, 8'd9,  8'd3,  ALU_SUB, 8'd20, 8'd5, ALU_ADD,  2'b10, 8'd25,  8'd20};
    vecs[5]  = '{2'b01, 8'hF0, 8'h0F, ALU_OR,  8'd20, 8'd5, ALU_ADD,  2'b01, 8'hFF,  8'hF0};
    vecs[6]  = '{2'b00, 8'd9,  8'd3,  ALU_SUB, 8'd20, 8'd5, ALU_ADD,  2'b00, 8'd0,   8'd0};
    vecs[7]  = '{2'b00, 8'd9,  8'd3,  ALU_SUB, 8'd20, 8'd5, ALU_ADD,  2'b00, 8'd0,   8'd0};
    vecs[8]  = '{2'b10, 8'd9,  8'd3,  ALU_SUB, 8'h80, 8'd3, ALU_SRL,  2'b10, 8'h10,  8'h80};
    vecs[9]  = '{2'b00, 8'd9,  8'd3,  ALU_SUB, 8'd20, 8'd5, ALU_ADD,  2'b00, 8'd0,   8'd0};
    vecs[10] = '{2'b11, 8'd200, 8'd100, ALU_ADD, 8'd20, 8'd5, ALU_ADD, 2'b01, 8'd44,  8'd200};
    vecs[11] = '{2'b10, 8'd9,  8'd3,  ALU_SUB, 8'd3,  8'd7, ALU_SLTU, 2'b10, 8'd1,   8'd3};
    vecs[12] = '{2'b00, 8'd9,  8'd3,  ALU_SUB, 8'd20, 8'd5, ALU_ADD,  2'b00, 8'd0,   8'd0};

    set_ops();
    repeat (2) @(posedge clk);
    #1;
    chk("reset grant", 32'(grant), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset timeout", 32'(timeout), 32'd0);
    chk("reset alu_a", 32'(alu_a), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      req = vecs[i].req;
      a0 = vecs[i].a0; b0 = vecs[i].b0; op0 = vecs[i].op0;
      a1 = vecs[i].a1; b1 = vecs[i].b1; op1 = vecs[i].op1;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d grant", i), 32'(grant), 32'(vecs[i].grant));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(|vecs[i].grant));
      chk($sformatf("vec%0d res", i), 32'(res), 32'(vecs[i].res));
      chk($sformatf("vec%0d alu_a", i), 32'(alu_a), 32'(vecs[i].alu_a));
    end

    // Idle mux outputs zero, and a request withdrawn before the edge is never granted.
    set_ops();
    #1;
    chk("idle alu_a", 32'(alu_a), 32'd0);
    chk("idle alu_b", 32'(alu_b), 32'd0);
    chk("idle alu_op", 32'(alu_op), 32'd0);
    req = 2'b01;
    #2;
    req = 2'b00;
    @(posedge clk);
    #1;
    chk("pulse grant", 32'(grant), 32'd0);
    chk("pulse busy", 32'(busy), 32'd0);

    // Both units contend; each holds three cycles, releases and re-requests.
    step(2'b11, 2'b01, "alt0");
    step(2'b11, 2'b01, "alt1");
    step(2'b11, 2'b01, "alt2");
    step(2'b10, 2'b10, "alt3");
    step(2'b11, 2'b10, "alt4");
    step(2'b11, 2'b10, "alt5");
    step(2'b01, 2'b01, "alt6");
    step(2'b11, 2'b01, "alt7");
    step(2'b11, 2'b01, "alt8");
    step(2'b10, 2'b10, "alt9");
    chk("alt9 alu_a", 32'(alu_a), 32'd20);

    // Reset in the middle of unit 1's session.
    req = 2'b11;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst grant", 32'(grant), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst timeout", 32'(timeout), 32'd0);
    rst = 1'b1;
    step(2'b11, 2'b01, "postrst");
    step(2'b00, 2'b00, "postrst_idle");

`ifdef ALU_ARB_TIMEOUT_EN
    step(2'b01, 2'b01, "to_grant");
    req = 2'b11;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("to_hold%0d grant", i), 32'(grant), 32'd1);
      chk($sformatf("to_hold%0d timeout", i), 32'(timeout), 32'd0);
    end
    @(posedge clk);
    #1;
    chk("to_revoke grant", 32'(grant), 32'd2);
    chk("to_revoke timeout", 32'(timeout), 32'd1);
    @(posedge clk);
    #1;
    chk("to_after grant", 32'(grant), 32'd2);
    chk("to_after timeout", 32'(timeout), 32'd0);
    step(2'b01, 2'b00, "to_masked");
    step(2'b00, 2'b00, "to_unmask");
    step(2'b01, 2'b01, "to_regrant");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
